bec_io_loader: RTL and testbench

Host-side sequencer that sits directly upstream (and on the readback path, downstream) of the binary-Edwards-curve scalar-multiply core. It performs these steps in order:
- accepts the scalar key and six 163-bit operands as a 32-bit word stream;
- drives the core's download handshake;
- serves one key bit per ladder iteration;
- when the core is done, reads back the two result coordinates as a 32-bit word stream.

---
 rtl/bec_io_loader.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_bec_io_loader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bec_io_loader.sv
// bec_io_loader: host-side sequencer for the binary-Edwards-curve scalar-multiply core.
// Takes the key plus six 163-bit operands as 32-bit words, downloads them into
// the core, feeds key bits MSB first during the ladder, then streams back the
// two result coordinates as 32-bit words.
module bec_io_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy,
  output logic         bec_load_data,
  output logic [2:0]   bec_load_status,
  output logic [162:0] bec_data_in,
  output logic         bec_trigLoad,
  output logic         bec_enable,
  output logic         bec_ki,
  input  logic         bec_next_key,
  input  logic [3:0]   bec_status,
  input  logic         bec_done,
  input  logic [162:0] bec_data_out
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_KEY   = 4'd1,
    S_REQ   = 4'd2,
    S_OPND  = 4'd3,
    S_PUSH  = 4'd4,
    S_ALIGN = 4'd5,
    S_RUN   = 4'd6,
    S_RDA   = 4'd7,
    S_RDB   = 4'd8,
    S_OUTB  = 4'd9
  } state_t;

  state_t         state_r;
  logic [162:0]   key_r;
  logic [162:0]   asm_r;
  logic [162:0]   out_sr_r;
  logic [2:0]     idx_r;
  logic [2:0]     dl_cnt_r;
  logic [2:0]     wcnt_r;
  logic [2:0]     ocnt_r;
  logic [7:0]     bit_idx_r;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [31:0]    out_data_r;
  logic           busy_r;
  logic           load_data_r;
  logic [2:0]     load_status_r;
  logic           trig_r;
  logic           enable_r;
  logic           ki_r;

  logic           in_acc_s;
  logic           out_acc_s;
  logic [2:0]     dl_nxt_s;
  logic           unused_status_s;

  // Merge one 32-bit host word into its slot of a 163-bit value; word 5 keeps only bits [2:0].
  function automatic logic [162:0] put_word(input logic [162:0] cur,
                                            input logic [2:0]   sel,
                                            input logic [31:0]  w);
    logic [162:0] r;
    r = cur;
    case (sel)
      3'd0:    r[31:0]    = w;
      3'd1:    r[63:32]   = w;
      3'd2:    r[95:64]   = w;
      3'd3:    r[127:96]  = w;
      3'd4:    r[159:128] = w;
      3'd5:    r[162:160] = w[2:0];
      default: r = cur;
    endcase
    return r;
  endfunction

  // Modulo-7 increment used to track the core's download-phase iteration counter.
  function automatic logic [2:0] mod7_inc(input logic [2:0] v);
    logic [2:0] r;
    if (v == 3'd6) begin
      r = 3'd0;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

  assign in_acc_s        = in_valid & in_ready_r;
  assign out_acc_s       = out_valid_r & out_ready;
  // idle / proc / upload flags are not needed: bec_done carries the upload state.
  assign unused_status_s = ^{bec_status[3], bec_status[1:0]};

  // Next value of the download-cycle counter: advances on every cycle the core reports download.
  always_comb begin
    dl_nxt_s = dl_cnt_r;
    if (bec_status[2]) begin
      dl_nxt_s = mod7_inc(dl_cnt_r);
    end else begin
      dl_nxt_s = dl_cnt_r;
    end
  end

  // Main sequencer: word collection, core download, key serving and readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      key_r         <= 163'd0;
      asm_r         <= 163'd0;
      out_sr_r      <= 163'd0;
      idx_r         <= 3'd0;
      dl_cnt_r      <= 3'd0;
      wcnt_r        <= 3'd0;
      ocnt_r        <= 3'd0;
      bit_idx_r     <= 8'd162;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= 32'd0;
      busy_r        <= 1'b0;
      load_data_r   <= 1'b0;
      load_status_r <= 3'd0;
      trig_r        <= 1'b0;
      enable_r      <= 1'b0;
      ki_r          <= 1'b0;
    end else begin
      // While waiting for the core, hold the counter at 0 so the core's first
      // download cycle is counted as 0, exactly like the core's own counter.
      if (state_r == S_REQ) begin
        dl_cnt_r <= bec_status[2] ? 3'd1 : 3'd0;
      end else begin
        dl_cnt_r <= dl_nxt_s;
      end

      case (state_r)
        S_IDLE: begin
          in_ready_r <= 1'b1;
          if (in_acc_s) begin
            key_r   <= put_word(key_r, 3'd0, in_data);
            wcnt_r  <= 3'd1;
            busy_r  <= 1'b1;
            state_r <= S_KEY;
          end
        end

        S_KEY: begin
          if (in_acc_s) begin
            key_r <= put_word(key_r, wcnt_r, in_data);
            if (wcnt_r == 3'd5) begin
              wcnt_r      <= 3'd0;
              bit_idx_r   <= 8'd162;
              ki_r        <= in_data[2];   // key bit 162 lives in bit 2 of word 5
              in_ready_r  <= 1'b0;
              load_data_r <= 1'b1;
              state_r     <= S_REQ;
            end else begin
              wcnt_r <= wcnt_r + 3'd1;
            end
          end
        end

        S_REQ: begin
          if (bec_status[2]) begin
            load_data_r <= 1'b0;
            idx_r       <= 3'd0;
            in_ready_r  <= 1'b1;
            state_r     <= S_OPND;
          end
        end

        S_OPND: begin
          if (in_acc_s) begin
            asm_r <= put_word(asm_r, wcnt_r, in_data);
            if (wcnt_r == 3'd5) begin
              wcnt_r        <= 3'd0;
              in_ready_r    <= 1'b0;
              trig_r        <= 1'b1;
              load_status_r <= idx_r;
              state_r       <= S_PUSH;
            end else begin
              wcnt_r <= wcnt_r + 3'd1;
            end
          end
        end

        S_PUSH: begin
          trig_r        <= 1'b0;
          load_status_r <= 3'd0;
          idx_r         <= idx_r + 3'd1;
          if (idx_r == 3'd5) begin
            // Enable may already be due in the very next cycle.
            enable_r <= (dl_nxt_s == 3'd6);
            state_r  <= S_ALIGN;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= S_OPND;
          end
        end

        S_ALIGN: begin
          // Enable only while the core's counter reads 6 so it wraps to 0 entering processing.
          if (enable_r) begin
            enable_r <= 1'b0;
            state_r  <= S_RUN;
          end else begin
            enable_r <= (dl_nxt_s == 3'd6);
          end
        end

        S_RUN: begin
          if (bec_next_key && (bit_idx_r != 8'd0)) begin
            bit_idx_r <= bit_idx_r - 8'd1;
            ki_r      <= key_r[bit_idx_r - 8'd1];
          end
          if (bec_done) begin
            state_r <= S_RDA;
          end
        end

        S_RDA: begin
          if (!out_valid_r) begin
            out_data_r  <= bec_data_out[31:0];
            out_sr_r    <= {32'd0, bec_data_out[162:32]};
            out_valid_r <= 1'b1;
            ocnt_r      <= 3'd0;
          end else if (out_acc_s) begin
            if (ocnt_r == 3'd5) begin
              out_valid_r   <= 1'b0;
              load_status_r <= 3'd1;
              state_r       <= S_RDB;
            end else begin
              ocnt_r     <= ocnt_r + 3'd1;
              out_data_r <= out_sr_r[31:0];
              out_sr_r   <= {32'd0, out_sr_r[162:32]};
            end
          end
        end

        S_RDB: begin
          // Selecting coordinate B also tells the core to drop back to idle.
          out_data_r    <= bec_data_out[31:0];
          out_sr_r      <= {32'd0, bec_data_out[162:32]};
          out_valid_r   <= 1'b1;
          ocnt_r        <= 3'd0;
          load_status_r <= 3'd0;
          state_r       <= S_OUTB;
        end

        S_OUTB: begin
          if (out_acc_s) begin
            if (ocnt_r == 3'd5) begin
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
              state_r     <= S_IDLE;
            end else begin
              ocnt_r     <= ocnt_r + 3'd1;
              out_data_r <= out_sr_r[31:0];
              out_sr_r   <= {32'd0, out_sr_r[162:32]};
            end
          end
        end

        default: begin
          state_r       <= S_IDLE;
          in_ready_r    <= 1'b0;
          out_valid_r   <= 1'b0;
          busy_r        <= 1'b0;
          load_data_r   <= 1'b0;
          load_status_r <= 3'd0;
          trig_r        <= 1'b0;
          enable_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_r;
  assign out_valid       = out_valid_r;
  assign out_data        = out_data_r;
  assign busy            = busy_r;
  assign bec_load_data   = load_data_r;
  assign bec_load_status = load_status_r;
  assign bec_data_in     = asm_r;
  assign bec_trigLoad    = trig_r;
  assign bec_enable      = enable_r;
  assign bec_ki          = ki_r;

endmodule

// File: tb/tb_bec_io_loader.sv
// Testbench for bec_io_loader: random host traffic, a behavioural core model
// and scoreboards for operand downloads, key bits and readback words.
module tb_bec_io_loader;

  localparam int C_IDLE = 0;
  localparam int C_DLOAD = 1;
  localparam int C_PROC = 2;
  localparam int C_UP = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;
  logic         bec_load_data;
  logic [2:0]   bec_load_status;
  logic [162:0] bec_data_in;
  logic         bec_trigLoad;
  logic         bec_enable;
  logic         bec_ki;
  logic         bec_next_key;
  logic [3:0]   bec_status;
  logic         bec_done;
  logic [162:0] bec_data_out;

  int n_checks = 0;
  int n_pass = 0;

  // core model state
  int core_st = C_IDLE;
  int core_iter = 0;
  int wait_c = 0;
  int pcyc = 0;
  int npulse = 0;
  int np_seen = 0;
  int core_dly = 0;
  int sel1_cnt = 0;
  bit first_proc = 1'b0;
  logic nk_drv = 1'b0;
  logic [162:0] key_ref = '0;
  logic [162:0] res_a = '0;
  logic [162:0] res_b = '0;

  // scoreboards
  logic [165:0] tl_q[$];
  logic [31:0]  out_q[$];
  logic [162:0] ops_g[6];

  // readback flow control
  bit rnd_ready_g = 1'b0;
  bit out_stall_g = 1'b0;
  bit stall_done = 1'b0;
  int stall_left = 0;
  int out_words = 0;

  always #5 clk = ~clk;

  bec_io_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .bec_load_data(bec_load_data), .bec_load_status(bec_load_status),
    .bec_data_in(bec_data_in), .bec_trigLoad(bec_trigLoad), .bec_enable(bec_enable),
    .bec_ki(bec_ki), .bec_next_key(bec_next_key), .bec_status(bec_status),
    .bec_done(bec_done), .bec_data_out(bec_data_out)
  );

  assign bec_next_key = nk_drv;
  assign bec_status   = (core_st == C_IDLE)  ? 4'b1000 :
                        (core_st == C_DLOAD) ? 4'b0100 :
                        (core_st == C_PROC)  ? 4'b0010 : 4'b0001;
  assign bec_done     = (core_st == C_UP);
  assign bec_data_out = (core_st != C_UP) ? 163'd0 :
                        (bec_load_status == 3'd0) ? res_a :
                        (bec_load_status == 3'd1) ? res_b : 163'd0;

  task automatic chk(input string nm, input logic [162:0] act, input logic [162:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0];
  endfunction

  function automatic logic [31:0] word_of(input logic [162:0] v, input int i);
    logic [191:0] ext;
    ext = {29'd0, v};
    return ext[i*32 +: 32];
  endfunction

  // Core model: idle -> download (mod-7 counter) -> processing (163 key pulses) -> upload.
  initial begin : core_model
    int nxt;
    logic nk_n;
    int kidx;
    logic [165:0] e;
    forever begin
      @(negedge clk);
      nxt = core_st;
      nk_n = 1'b0;
      if (!rst_n) begin
        nxt = C_IDLE;
        wait_c = 0;
      end else begin
        case (core_st)
          C_IDLE: begin
            if (bec_load_data) begin
              if (wait_c >= core_dly) begin
                nxt = C_DLOAD;
                wait_c = 0;
                core_iter = 0;
              end else wait_c++;
            end else wait_c = 0;
          end
          C_DLOAD: begin
            if (bec_trigLoad) begin
              chk("tl_expected", tl_q.size() != 0, 1'b1);
              if (tl_q.size() != 0) begin
                e = tl_q.pop_front();
                chk("tl_status", bec_load_status, e[165:163]);
                chk("tl_data", bec_data_in, e[162:0]);
                chk("ki_download", bec_ki, key_ref[162]);
              end
            end
            if (bec_enable) begin
              chk("enable_after_all_ops", tl_q.size(), 0);
              nxt = C_PROC;
              first_proc = 1'b1;
              pcyc = 0;
              npulse = 0;
              np_seen = 0;
            end
            core_iter = (core_iter + 1) % 7;
          end
          C_PROC: begin
            if (first_proc) begin
              chk("iter_at_first_proc", core_iter, 0);
              first_proc = 1'b0;
            end
            kidx = (np_seen >= 162) ? 0 : 162 - np_seen;
            chk("ki_proc", bec_ki, key_ref[kidx]);
            if (bec_next_key) np_seen++;
            pcyc++;
            core_iter = (core_iter + 1) % 7;
            if (npulse == 162) begin
              nxt = C_UP;
              nk_n = 1'b1;
              npulse++;
            end else if (pcyc % 3 == 0) begin
              nk_n = 1'b1;
              npulse++;
            end
          end
          default: begin
            kidx = (np_seen >= 162) ? 0 : 162 - np_seen;
            chk("ki_upload", bec_ki, key_ref[kidx]);
            if (bec_next_key) np_seen++;
            if (bec_load_status == 3'd1) begin
              sel1_cnt++;
              nxt = C_IDLE;
            end
          end
        endcase
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        core_st = nxt;
        nk_drv = nk_n;
      end else begin
        core_st = C_IDLE;
        nk_drv = 1'b0;
      end
    end
  end

  // Host readback flow control: random or always-ready, with an optional 20-cycle stall.
  initial begin : ready_gen
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_stall_g && out_words == 3 && !stall_done) begin
        stall_done = 1'b1;
        stall_left = 20;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd_ready_g ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Output monitor: readback scoreboard, hold-under-backpressure and strobe-shape checks.
  initial begin : monitor
    bit prev_trig;
    bit prev_en;
    bit held;
    logic [31:0] held_data;
    logic [31:0] e;
    prev_trig = 1'b0;
    prev_en = 1'b0;
    held = 1'b0;
    held_data = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bec_trigLoad) chk("trig_single_cycle", prev_trig, 1'b0);
        if (bec_enable) chk("enable_single_cycle", prev_en, 1'b0);
        prev_trig = bec_trigLoad;
        prev_en = bec_enable;
        if (bec_load_status == 3'd1)
          chk("sel1_context", bec_trigLoad || (core_st == C_UP), 1'b1);
        if (held) begin
          chk("out_valid_held", out_valid, 1'b1);
          chk("out_data_held", out_data, held_data);
        end
        if (out_valid) begin
          if (out_ready) begin
            held = 1'b0;
            chk("out_expected", out_q.size() != 0, 1'b1);
            if (out_q.size() != 0) begin
              e = out_q.pop_front();
              chk("out_word", out_data, e);
            end
            out_words++;
          end else begin
            held = 1'b1;
            held_data = out_data;
          end
        end else begin
          held = 1'b0;
        end
      end else begin
        prev_trig = 1'b0;
        prev_en = 1'b0;
        held = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_load_data"}, bec_load_data, 1'b0);
    chk({tag, "_load_status"}, bec_load_status, 3'd0);
    chk({tag, "_data_in"}, bec_data_in, 163'd0);
    chk({tag, "_trigLoad"}, bec_trigLoad, 1'b0);
    chk({tag, "_enable"}, bec_enable, 1'b0);
    chk({tag, "_ki"}, bec_ki, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    while (!acc && g < 400) begin
      in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = in_valid ? w : $urandom;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    if (!acc) chk("in_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_val(input logic [162:0] v, input bit stall);
    logic [31:0] w;
    for (int i = 0; i < 6; i++) begin
      w = word_of(v, i);
      if (i == 5) w[31:3] = 29'($urandom);   // ignored bits of the top word
      send_word(w, stall);
    end
  endtask

  task automatic run_load(input logic [162:0] key, input logic [162:0] a, input logic [162:0] b,
                          input bit stall_in, input bit rnd_rdy, input bit ostall, input bit abort);
    int g;
    key_ref = key;
    res_a = a;
    res_b = b;
    core_dly = $urandom_range(0, 4);
    rnd_ready_g = rnd_rdy;
    out_stall_g = ostall;
    stall_done = 1'b0;
    sel1_cnt = 0;
    out_words = 0;
    for (int j = 0; j < 6; j++) tl_q.push_back({3'(j), ops_g[j]});
    if (!abort) begin
      for (int i = 0; i < 6; i++) out_q.push_back(word_of(a, i));
      for (int i = 0; i < 6; i++) out_q.push_back(word_of(b, i));
    end
    send_val(key, stall_in);
    for (int j = 0; j < 6; j++) send_val(ops_g[j], stall_in);
    if (abort) begin
      g = 0;
      while (!(core_st == C_PROC && np_seen >= 10) && g < 2000) begin
        @(negedge clk);
        g++;
      end
      chk("abort_reach_run", core_st == C_PROC, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_tl_q_empty", tl_q.size(), 0);
    end else begin
      g = 0;
      while ((busy || out_q.size() != 0) && g < 5000) begin
        @(posedge clk);
        #1;
        g++;
      end
      #2;
      chk("run_complete", busy, 1'b0);
      chk("out_q_empty", out_q.size(), 0);
      chk("tl_q_empty", tl_q.size(), 0);
      chk("sel1_exactly_once", sel1_cnt, 1);
      chk("core_back_idle", core_st == C_IDLE, 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : main
    logic [162:0] k;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // directed: key bits 162 and 0, operands 1..6, A all ones, B = 1
    k = (163'd1 << 162) | 163'd1;
    for (int j = 0; j < 6; j++) ops_g[j] = 163'(j + 1);
    run_load(k, {163{1'b1}}, 163'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // random traffic with input stalls and random readback ready
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 6; j++) ops_g[j] = rand163();
      run_load(rand163(), rand163(), rand163(), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // 20-cycle readback backpressure
    for (int j = 0; j < 6; j++) ops_g[j] = rand163();
    run_load(rand163(), rand163(), rand163(), 1'b1, 1'b0, 1'b1, 1'b0);

    // reset in the middle of the ladder, then a full clean load
    for (int j = 0; j < 6; j++) ops_g[j] = rand163();
    run_load(rand163(), rand163(), rand163(), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) ops_g[j] = rand163();
    run_load(rand163(), rand163(), rand163(), 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
